bsg_fifo_1r1w_rolly_replay_ctrl: RTL and testbench

//  Go-back-N replay controller for the read side of bsg_fifo_1r1w_rolly_hardened.

---
 rtl/bsg_fifo_1r1w_rolly_replay_ctrl_if.sv | 36 +++
 rtl/bsg_fifo_1r1w_rolly_replay_ctrl.sv | 97 +++++++++
 tb/tb_bsg_fifo_1r1w_rolly_replay_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_fifo_1r1w_rolly_replay_ctrl_if.sv
// Bundle of FIFO-side, link-side and status signals for the go-back-N replay controller.
// The master modport is the controller; slave is the FIFO/link environment.
interface bsg_fifo_1r1w_rolly_replay_ctrl_if #(
    parameter int width_p     = 32,
    parameter int lg_size_p   = 2,
    parameter int max_retry_p = 3
);
    localparam int retry_w_lp = (max_retry_p < 1) ? 1 : $clog2(max_retry_p + 1);

    logic [width_p-1:0]    fifo_data_i;
    logic                  fifo_v_i;
    logic                  fifo_yumi_o;
    logic                  fifo_ack_v_o;
    logic                  fifo_rollback_v_o;
    logic [width_p-1:0]    link_data_o;
    logic [lg_size_p:0]    link_seq_o;
    logic                  link_v_o;
    logic                  link_ready_i;
    logic                  resp_v_i;
    logic                  resp_nack_i;
    logic [lg_size_p:0]    outstanding_o;
    logic [retry_w_lp-1:0] retry_cnt_o;
    logic                  error_o;

    modport master (
        input  fifo_data_i, fifo_v_i, link_ready_i, resp_v_i, resp_nack_i,
        output fifo_yumi_o, fifo_ack_v_o, fifo_rollback_v_o, link_data_o, link_seq_o,
               link_v_o, outstanding_o, retry_cnt_o, error_o
    );

    modport slave (
        output fifo_data_i, fifo_v_i, link_ready_i, resp_v_i, resp_nack_i,
        input  fifo_yumi_o, fifo_ack_v_o, fifo_rollback_v_o, link_data_o, link_seq_o,
               link_v_o, outstanding_o, retry_cnt_o, error_o
    );
endinterface

// File: rtl/bsg_fifo_1r1w_rolly_replay_ctrl.sv
// Go-back-N replay controller for the read side of a rolly FIFO: speculative send,
// in-order commit on ACK, rewind-and-resend on NACK/timeout, fatal after bounded retries.
module bsg_fifo_1r1w_rolly_replay_ctrl #(
    parameter int width_p     = 32,
    parameter int lg_size_p   = 2,
    parameter int timeout_p   = 64,
    parameter int max_retry_p = 3
) (
    input logic clk_i,
    input logic reset_i,
    bsg_fifo_1r1w_rolly_replay_ctrl_if.master io
);
    localparam int cnt_w_lp   = lg_size_p + 1;
    localparam int timer_w_lp = $clog2(timeout_p + 1);
    localparam int retry_w_lp = (max_retry_p < 1) ? 1 : $clog2(max_retry_p + 1);

    localparam logic [cnt_w_lp-1:0]   window_lp    = cnt_w_lp'(1 << lg_size_p);
    localparam logic [cnt_w_lp-1:0]   cnt_one_lp   = cnt_w_lp'(1);
    localparam logic [timer_w_lp-1:0] timer_one_lp = timer_w_lp'(1);
    localparam logic [timer_w_lp-1:0] timer_end_lp = timer_w_lp'(timeout_p - 1);
    localparam logic [retry_w_lp-1:0] retry_one_lp = retry_w_lp'(1);
    localparam logic [retry_w_lp-1:0] retry_max_lp = retry_w_lp'(max_retry_p);

    localparam logic [1:0] SEND     = 2'd0;
    localparam logic [1:0] ROLLBACK = 2'd1;
    localparam logic [1:0] ERROR    = 2'd2;

    logic [1:0]            state_r, state_n;
    logic [cnt_w_lp-1:0]   outstanding_r, send_seq_r, ack_seq_r;
    logic [timer_w_lp-1:0] timer_r;
    logic [retry_w_lp-1:0] retry_r;

    logic in_send, has_out, send_hs, ack, nack, timeout, replay;

    assign in_send = (state_r == SEND);
    assign has_out = (outstanding_r != '0);

    assign io.link_v_o    = in_send & io.fifo_v_i & (outstanding_r < window_lp);
    assign io.link_data_o = io.fifo_data_i;
    assign io.link_seq_o  = send_seq_r;
    assign send_hs        = io.link_v_o & io.link_ready_i;
    assign io.fifo_yumi_o = send_hs;

    // Responses only count while something is in flight and we are sending.
    assign ack     = in_send & has_out & io.resp_v_i & ~io.resp_nack_i;
    assign nack    = in_send & has_out & io.resp_v_i &  io.resp_nack_i;
    assign timeout = in_send & has_out & ~ack & (timer_r == timer_end_lp);
    assign replay  = nack | timeout;

    assign io.fifo_ack_v_o      = ack;
    assign io.fifo_rollback_v_o = (state_r == ROLLBACK);
    assign io.outstanding_o     = outstanding_r;
    assign io.retry_cnt_o       = retry_r;
    assign io.error_o           = (state_r == ERROR);

    always_comb begin
        state_n = state_r;
        case (state_r)
            SEND:     if (replay) state_n = (retry_r == retry_max_lp) ? ERROR : ROLLBACK;
            ROLLBACK: state_n = SEND;
            default:  state_n = ERROR;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r       <= SEND;
            outstanding_r <= '0;
            send_seq_r    <= '0;
            ack_seq_r     <= '0;
            timer_r       <= '0;
            retry_r       <= '0;
        end else begin
            state_r <= state_n;
            case (state_r)
                SEND: begin
                    if (send_hs) send_seq_r <= send_seq_r + cnt_one_lp;
                    if (ack) begin
                        ack_seq_r <= ack_seq_r + cnt_one_lp;
                        retry_r   <= '0;
                    end
                    if (send_hs && !ack)      outstanding_r <= outstanding_r + cnt_one_lp;
                    else if (!send_hs && ack) outstanding_r <= outstanding_r - cnt_one_lp;
                    timer_r <= (has_out && !ack) ? timer_r + timer_one_lp : '0;
                end
                // The FIFO rewinds to its committed pointer this cycle; resend from the oldest unacked seq.
                ROLLBACK: begin
                    outstanding_r <= '0;
                    send_seq_r    <= ack_seq_r;
                    timer_r       <= '0;
                    retry_r       <= retry_r + retry_one_lp;
                end
                default: timer_r <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_bsg_fifo_1r1w_rolly_replay_ctrl.sv
// Bench for the go-back-N replay controller: a rolly-FIFO environment plus a
// queue-based behavioural model of the send window, driven by directed and random stimulus.
module tb_bsg_fifo_1r1w_rolly_replay_ctrl;
    localparam int W   = 32;
    localparam int LG  = 2;
    localparam int TO  = 16;
    localparam int MR  = 3;
    localparam int WIN = 1 << LG;
    localparam int SEQ_MOD = 2 * WIN;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    bsg_fifo_1r1w_rolly_replay_ctrl_if #(.width_p(W), .lg_size_p(LG), .max_retry_p(MR)) io();

    bsg_fifo_1r1w_rolly_replay_ctrl #(
        .width_p(W), .lg_size_p(LG), .timeout_p(TO), .max_retry_p(MR)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .io     (io)
    );

    always #5 clk = ~clk;

    // Rolly FIFO environment: write pointer, speculative read pointer, committed pointer.
    logic [W-1:0] mem [0:255];
    int wptr = 0;
    int f_rptr, f_cptr;

    assign io.fifo_v_i    = (f_rptr != wptr);
    assign io.fifo_data_i = mem[f_rptr[7:0]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            f_rptr <= 0;
            f_cptr <= 0;
        end else if (io.fifo_rollback_v_o) begin
            f_rptr <= f_cptr;
        end else begin
            if (io.fifo_yumi_o)  f_rptr <= f_rptr + 1;
            if (io.fifo_ack_v_o) f_cptr <= f_cptr + 1;
        end
    end

    // Reference model: mode 0 sending, 1 rewinding, 2 dead; in-flight words kept as a queue of seqs.
    int m_mode, m_next, m_ack_seq, m_timer, m_retry, m_rptr, m_cptr;
    int m_q[$];
    logic e_link_v, e_yumi, e_ack, e_rb, e_err, e_replay;
    logic [W-1:0] e_data;

    task automatic model_reset();
        m_mode = 0; m_next = 0; m_ack_seq = 0; m_timer = 0; m_retry = 0;
        m_rptr = 0; m_cptr = 0; wptr = 0;
        m_q.delete();
    endtask

    task automatic predict();
        int n;
        logic sending;
        n = m_q.size();
        sending  = (m_mode == 0);
        e_link_v = sending && (m_rptr != wptr) && (n < WIN);
        e_yumi   = e_link_v && io.link_ready_i;
        e_data   = mem[m_rptr[7:0]];
        e_ack    = sending && (n > 0) && io.resp_v_i && !io.resp_nack_i;
        e_replay = sending && (n > 0) &&
                   ((io.resp_v_i && io.resp_nack_i) || (!e_ack && m_timer == TO - 1));
        e_rb     = (m_mode == 1);
        e_err    = (m_mode == 2);
    endtask

    task automatic commit();
        int n0;
        n0 = m_q.size();
        if (m_mode == 1) begin
            m_q.delete();
            m_next = m_ack_seq;
            m_rptr = m_cptr;
            m_timer = 0;
            m_retry++;
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (e_yumi) begin
                m_q.push_back(m_next);
                m_next = (m_next + 1) % SEQ_MOD;
                m_rptr++;
            end
            if (e_ack) begin
                void'(m_q.pop_front());
                m_ack_seq = (m_ack_seq + 1) % SEQ_MOD;
                m_cptr++;
                m_retry = 0;
            end
            m_timer = (n0 > 0 && !e_ack) ? m_timer + 1 : 0;
            if (e_replay) m_mode = (m_retry == MR) ? 2 : 1;
        end
    endtask

    function automatic logic [44:0] exp_vec();
        return {e_link_v, e_yumi, e_ack, e_rb, e_err, 3'(m_next), 3'(m_q.size()),
                2'(m_retry), e_link_v ? e_data : 32'd0};
    endfunction

    function automatic logic [44:0] obs_vec();
        return {io.link_v_o, io.fifo_yumi_o, io.fifo_ack_v_o, io.fifo_rollback_v_o, io.error_o,
                io.link_seq_o, io.outstanding_o, io.retry_cnt_o,
                io.link_v_o ? io.link_data_o : 32'd0};
    endfunction

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wptr[7:0]] = $urandom;
            wptr++;
        end
    endtask

    task automatic drive(input logic lr, input logic rv, input logic rn);
        io.link_ready_i = lr;
        io.resp_v_i     = rv;
        io.resp_nack_i  = rn;
        predict();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic do_reset();
        io.link_ready_i = 1'b0; io.resp_v_i = 1'b0; io.resp_nack_i = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        io.link_ready_i = 1'b0; io.resp_v_i = 1'b0; io.resp_nack_i = 1'b0;
        #1 rst = 1'b1;
        model_reset();
        #1;
        predict();
        checks++;
        if ({io.outstanding_o, io.retry_cnt_o, io.error_o, io.fifo_rollback_v_o, io.fifo_ack_v_o,
             io.link_v_o, io.fifo_yumi_o, io.link_seq_o} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state got out=%0d retry=%0d err=%b rb=%b ack=%b v=%b seq=%0d required all 0",
                     io.outstanding_o, io.retry_cnt_o, io.error_o, io.fifo_rollback_v_o,
                     io.fifo_ack_v_o, io.link_v_o, io.link_seq_o);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model got %h required %h", obs_vec(), exp_vec());
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_window_fill();
        int sends = 0;
        do_reset();
        push(6);
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL fill c%0d got %h required %h", c, obs_vec(), exp_vec());
            end
            if (io.fifo_yumi_o) begin
                checks++;
                if (io.link_seq_o !== 3'(sends)) begin
                    errors++;
                    $display("FAIL fill_seq got %0d required %0d", io.link_seq_o, sends);
                end
                sends++;
            end
            advance();
        end
        checks++;
        if (sends != 4 || io.outstanding_o !== 3'd4) begin
            errors++;
            $display("FAIL fill_window got sends=%0d out=%0d required sends=4 out=4", sends, io.outstanding_o);
        end
    endtask

    task automatic test_acks_reopen();
        int acks = 0;
        int sends = 0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, c < 2, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reopen c%0d got %h required %h", c, obs_vec(), exp_vec());
            end
            if (io.fifo_ack_v_o) acks++;
            if (io.fifo_yumi_o) begin
                checks++;
                if (io.link_seq_o !== 3'(4 + sends)) begin
                    errors++;
                    $display("FAIL reopen_seq got %0d required %0d", io.link_seq_o, 4 + sends);
                end
                sends++;
            end
            advance();
        end
        checks++;
        if (acks != 2 || sends != 2 || io.outstanding_o !== 3'd4) begin
            errors++;
            $display("FAIL reopen_counts got acks=%0d sends=%0d out=%0d required 2 2 4",
                     acks, sends, io.outstanding_o);
        end
    endtask

    task automatic test_nack();
        logic [W-1:0] d0;
        do_reset();
        push(3);
        d0 = mem[0];
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, c == 3, c == 3);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL nack c%0d got %h required %h", c, obs_vec(), exp_vec());
            end
            if (c == 4) begin
                checks++;
                if (io.fifo_rollback_v_o !== 1'b1 || io.link_v_o !== 1'b0) begin
                    errors++;
                    $display("FAIL nack_rewind got rb=%b v=%b required rb=1 v=0",
                             io.fifo_rollback_v_o, io.link_v_o);
                end
            end
            if (c == 5) begin
                checks++;
                if (io.link_v_o !== 1'b1 || io.link_seq_o !== 3'd0 || io.link_data_o !== d0 ||
                    io.retry_cnt_o !== 2'd1) begin
                    errors++;
                    $display("FAIL nack_resend got v=%b seq=%0d data=%h retry=%0d required 1 0 %h 1",
                             io.link_v_o, io.link_seq_o, io.link_data_o, io.retry_cnt_o, d0);
                end
            end
            advance();
        end
    endtask

    task automatic test_timeout();
        int first_rb = -1;
        do_reset();
        push(1);
        for (int c = 0; c < 22; c++) begin
            drive(c == 0, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL timeout c%0d got %h required %h", c, obs_vec(), exp_vec());
            end
            if (io.fifo_rollback_v_o === 1'b1 && first_rb < 0) first_rb = c;
            advance();
        end
        checks++;
        if (first_rb != 17) begin
            errors++;
            $display("FAIL timeout_cycle got %0d required 17", first_rb);
        end
    endtask

    task automatic test_exhaustion();
        int nacks = 0;
        int rbs = 0;
        logic rv;
        do_reset();
        push(8);
        for (int c = 0; c < 30; c++) begin
            rv = (nacks < 4) && (m_mode == 0) && (m_q.size() > 0);
            drive(1'b1, rv, rv);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL exhaust c%0d got %h required %h", c, obs_vec(), exp_vec());
            end
            if (io.fifo_rollback_v_o === 1'b1) rbs++;
            if (rv) nacks++;
            advance();
        end
        checks++;
        if (nacks != 4 || rbs != 3 || io.error_o !== 1'b1) begin
            errors++;
            $display("FAIL exhaust_counts got nacks=%0d rb=%0d err=%b required 4 3 1", nacks, rbs, io.error_o);
        end
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b1, 1'b0);
            checks++;
            if (io.link_v_o !== 1'b0 || io.fifo_ack_v_o !== 1'b0 || io.fifo_yumi_o !== 1'b0 ||
                io.error_o !== 1'b1) begin
                errors++;
                $display("FAIL dead c%0d got v=%b ack=%b yumi=%b err=%b required 0 0 0 1",
                         c, io.link_v_o, io.fifo_ack_v_o, io.fifo_yumi_o, io.error_o);
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        push(3);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0);
            advance();
        end
        checks++;
        if (io.outstanding_o !== 3'd3) begin
            errors++;
            $display("FAIL areset_pre got out=%0d required 3", io.outstanding_o);
        end
        #3 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (io.outstanding_o !== 3'd0 || io.error_o !== 1'b0 || io.retry_cnt_o !== 2'd0) begin
            errors++;
            $display("FAIL areset_now got out=%0d err=%b retry=%0d required 0 0 0",
                     io.outstanding_o, io.error_o, io.retry_cnt_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        push(2);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL areset_post c%0d got %h required %h", c, obs_vec(), exp_vec());
            end
            if (c == 0) begin
                checks++;
                if (io.link_v_o !== 1'b1 || io.link_seq_o !== 3'd0) begin
                    errors++;
                    $display("FAIL areset_seq got v=%b seq=%0d required v=1 seq=0", io.link_v_o, io.link_seq_o);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic lr, rv, rn;
        for (int c = 0; c < 1500; c++) begin
            if (c % 250 == 0) do_reset();
            if ($urandom_range(0, 2) == 0 && (wptr - m_cptr) < 200) push($urandom_range(1, 3));
            lr = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 2) == 0);
            rn = ($urandom_range(0, 6) == 0);
            drive(lr, rv, rn);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random c%0d got %h required %h", c, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    initial begin
        io.link_ready_i = 1'b0; io.resp_v_i = 1'b0; io.resp_nack_i = 1'b0;
        test_reset();
        test_window_fill();
        test_acks_reopen();
        test_nack();
        test_timeout();
        test_exhaustion();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
